// File: rtl/intr_ctrl.sv
// intr_ctrl: synchronizes, latches and masks device requests into cp0 intr[N_IRQ-1:0].
//   clk     system clock
//   clr     asynchronous active-high reset
//   dev_req raw device request lines, asynchronous to clk
//   addr    register index: 0 PEND, 1 MASK, 2 MODE, 3 ID, 4 LOST
//   WE/Din  bus write strobe and data
//   Dout    combinational read data
//   intr    PEND & MASK to cp0
//   any_irq OR of intr
module intr_ctrl #(
    parameter int N_IRQ       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int LOST_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] dev_req,
    input  logic [2:0]       addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic [N_IRQ-1:0] intr,
    output logic             any_irq
);
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] s;
    logic [N_IRQ-1:0] prev, pend, mask, mode, synced, edge_ev, w1c, pend_next;
    logic [LOST_W-1:0] lost;
    logic [31:0] id;
    logic lost_inc;
    wire unused_din = ^Din[31:N_IRQ];

    assign synced    = s[SYNC_STAGES-1];
    assign edge_ev   = synced & ~prev;
    assign w1c       = (WE && addr == 3'd0) ? Din[N_IRQ-1:0] & mode : '0;
    // Edge lines: a new event beats a same-cycle clear. Level lines follow the synced input.
    assign pend_next = (mode & ((pend & ~w1c) | edge_ev)) | (~mode & synced);
    assign lost_inc  = |(edge_ev & pend & mode);
    assign intr      = pend & mask;
    assign any_irq   = |intr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s    <= '0;
            prev <= '0;
            pend <= '0;
            mask <= '0;
            mode <= '0;
            lost <= '0;
        end else begin
            s    <= {s[SYNC_STAGES-2:0], dev_req};
            prev <= synced;
            pend <= pend_next;
            if (WE && addr == 3'd1) mask <= Din[N_IRQ-1:0];
            if (WE && addr == 3'd2) mode <= Din[N_IRQ-1:0];
            if (WE && addr == 3'd4) lost <= '0;
            else if (lost_inc && lost != '1) lost <= lost + 1'b1;
        end
    end

    // Highest-numbered active source wins; reported as index+1 so 0 means none.
    always_comb begin
        id = '0;
        for (int i = 0; i < N_IRQ; i++) if (intr[i]) id = 32'(i + 1);
    end

    assign Dout = addr == 3'd0 ? 32'(pend) :
                  addr == 3'd1 ? 32'(mask) :
                  addr == 3'd2 ? 32'(mode) :
                  addr == 3'd3 ? id :
                  addr == 3'd4 ? 32'(lost) : '0;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: scoreboard bench for intr_ctrl.
module tb_intr_ctrl;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [5:0]  dev_req = '0;
    logic [2:0]  addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic [5:0]  intr;
    logic        any_irq;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        bit          is_intr;
        logic [2:0]  a;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    intr_ctrl dut (
        .clk(clk), .clr(clr), .dev_req(dev_req), .addr(addr), .WE(WE),
        .Din(Din), .Dout(Dout), .intr(intr), .any_irq(any_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_r(input string tag, input logic [2:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.is_intr = 1'b0; e.a = a; e.v = v;
        sb.push_back(e);
    endtask

    task automatic exp_i(input string tag, input logic [5:0] v);
        exp_t e;
        e.tag = tag; e.is_intr = 1'b1; e.a = '0; e.v = {25'd0, |v, v};
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_intr) check(e.tag, {25'd0, any_irq, intr}, e.v);
            else begin
                addr = e.a;
                #1;
                check(e.tag, Dout, e.v);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; Din = d; WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    initial begin
        #2;
        for (int a = 0; a < 8; a++) exp_r("rst_rd", 3'(a), 32'd0);
        exp_i("rst_intr", 6'h00);
        drain();
        cyc(1);
        clr = 1'b0;
        cyc(1);

        // reset mid-operation
        wr(3'd1, 32'h3F);
        wr(3'd2, 32'h3F);
        dev_req = 6'h05;
        cyc(3);
        exp_r("pre_rst_pend", 3'd0, 32'h05);
        exp_i("pre_rst_intr", 6'h05);
        drain();
        cyc(1);
        #2 clr = 1'b1;
        #1;
        exp_i("arst_intr", 6'h00);
        for (int a = 0; a < 5; a++) exp_r("arst_rd", 3'(a), 32'd0);
        drain();
        dev_req = '0;
        cyc(1);
        clr = 1'b0;
        cyc(2);

        // edge latency and W1C
        wr(3'd2, 32'h01);
        wr(3'd1, 32'h01);
        dev_req[0] = 1'b1;
        cyc(1); exp_i("edge_k", 6'h00); drain();
        cyc(1); exp_i("edge_k1", 6'h00); drain();
        cyc(1); exp_i("edge_k2", 6'h01); exp_r("edge_id", 3'd3, 32'd1); drain();
        wr(3'd0, 32'h01);
        exp_i("edge_w1c", 6'h00); drain();
        cyc(2);
        exp_i("edge_no_new", 6'h00); drain();
        dev_req = '0;
        cyc(3);

        // set-vs-clear collision
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h08);
        wr(3'd1, 32'h08);
        dev_req[3] = 1'b1;
        cyc(3);
        exp_r("col_first", 3'd0, 32'h08); drain();
        dev_req[3] = 1'b0;
        cyc(3);
        dev_req[3] = 1'b1;
        cyc(2);
        wr(3'd0, 32'h08);
        exp_r("col_pend", 3'd0, 32'h08);
        exp_r("col_lost", 3'd4, 32'd1);
        exp_i("col_intr", 6'h08);
        drain();
        dev_req = '0;

        // level mode
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h20);
        cyc(2);
        dev_req[5] = 1'b1;
        cyc(1); exp_i("lvl_1", 6'h00); drain();
        cyc(1); exp_i("lvl_2", 6'h00); drain();
        cyc(1); exp_i("lvl_3", 6'h20); drain();
        wr(3'd0, 32'h20);
        exp_i("lvl_w1c", 6'h20); exp_r("lvl_pend", 3'd0, 32'h20); drain();
        cyc(1);
        dev_req[5] = 1'b0;
        cyc(1); exp_i("lvl_off1", 6'h20); drain();
        cyc(1); exp_i("lvl_off2", 6'h20); drain();
        cyc(1); exp_i("lvl_off3", 6'h00); drain();

        // priority and masking
        wr(3'd2, 32'h3F);
        wr(3'd1, 32'h0A);
        dev_req = 6'h2A;
        cyc(3);
        exp_r("pri_pend", 3'd0, 32'h2A);
        exp_i("pri_intr", 6'h0A);
        exp_r("pri_id", 3'd3, 32'd4);
        exp_r("pri_mask", 3'd1, 32'h0A);
        exp_r("pri_mode", 3'd2, 32'h3F);
        exp_r("pri_resv", 3'd6, 32'd0);
        drain();
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'h00);
        exp_i("msk_intr", 6'h00);
        exp_r("msk_id", 3'd3, 32'd0);
        drain();
        dev_req = '0;
        wr(3'd0, 32'h3F);
        cyc(3);
        exp_r("pri_clr", 3'd0, 32'h00); drain();

        // LOST saturation
        wr(3'd4, 32'h0);
        for (int n = 0; n < 10; n++) begin
            dev_req[1] = 1'b1; cyc(1);
            dev_req[1] = 1'b0; cyc(1);
        end
        cyc(3);
        exp_r("lost_9", 3'd4, 32'd9); drain();
        for (int n = 0; n < 290; n++) begin
            dev_req[1] = 1'b1; cyc(1);
            dev_req[1] = 1'b0; cyc(1);
        end
        cyc(3);
        exp_r("lost_sat", 3'd4, 32'd255); drain();
        wr(3'd4, 32'h1);
        exp_r("lost_clr", 3'd4, 32'd0); drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
